// File: rtl/id_decode_stage.sv
// RV32I decode/register-read stage: decodes OP, OP-IMM and LUI, owns the register file,
// and registers the ID/EX bundle. Build option ID_BYPASS_EN selects write-first bypass
// instead of a one-cycle RAW stall.
module id_decode_stage #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [31:0] id_ex_imm_i,
  output logic [4:0]  id_ex_rd,
  output logic        id_ex_wb_we,
  output logic [3:0]  id_ex_alu_opcode,
  output logic        id_ex_use_imm,
  output logic        id_ex_illegal
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NREG;
  endfunction

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign f3  = in_instr[14:12];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign f7  = in_instr[31:25];

  // Register file; x0 is never written and always reads 0.
  logic [31:0] rf_q [NREG];
  logic        rf_we;
  assign rf_we = wb_we && (wb_rd != 5'd0) && idx_ok(wb_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[wb_rd[IW-1:0]] <= wb_data;
    end
  end

  logic rs1_hit, rs2_hit;
  assign rs1_hit = wb_we && (wb_rd != 5'd0) && (wb_rd == rs1);
  assign rs2_hit = wb_we && (wb_rd != 5'd0) && (wb_rd == rs2);

  logic [31:0] rs1_rd, rs2_rd;
  always_comb begin
    rs1_rd = '0;
    rs2_rd = '0;
    if (rs1 != 5'd0 && idx_ok(rs1)) rs1_rd = rf_q[rs1[IW-1:0]];
    if (rs2 != 5'd0 && idx_ok(rs2)) rs2_rd = rf_q[rs2[IW-1:0]];
`ifdef ID_BYPASS_EN
    if (rs1_hit) rs1_rd = wb_data;
    if (rs2_hit) rs2_rd = wb_data;
`endif
  end

  // Handshake: an instruction transfers on a posedge where in_valid && in_ready;
  // in_ready never depends on in_valid or flush, only on reset and (without bypass) RAW hazards.
`ifdef ID_BYPASS_EN
  assign in_ready = !reset;
`else
  assign in_ready = !reset && !(rs1_hit || rs2_hit);
`endif

  logic accept;
  assign accept = in_valid && in_ready;

  logic        dec_illegal, dec_use_imm, dec_rs1_zero, use_rs1, use_rs2;
  logic [3:0]  dec_alu;
  logic [31:0] dec_imm;

  always_comb begin
    dec_illegal  = 1'b1;
    dec_alu      = ALU_ADD;
    dec_use_imm  = 1'b0;
    dec_imm      = {{20{in_instr[31]}}, in_instr[31:20]};
    dec_rs1_zero = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    case (opc)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (f3)
          3'b000: begin
            dec_alu     = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            dec_illegal = !(f7 == F7_BASE || f7 == F7_ALT);
          end
          3'b101: begin
            dec_alu     = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_illegal = !(f7 == F7_BASE || f7 == F7_ALT);
          end
          default: begin
            dec_alu     = base_alu(f3);
            dec_illegal = (f7 != F7_BASE);
          end
        endcase
      end
      OPC_OPIMM: begin
        use_rs1     = 1'b1;
        dec_use_imm = 1'b1;
        case (f3)
          3'b001: begin
            dec_alu     = ALU_SLL;
            dec_illegal = (f7 != F7_BASE);
          end
          3'b101: begin
            dec_alu     = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_illegal = !(f7 == F7_BASE || f7 == F7_ALT);
          end
          default: begin
            dec_alu     = base_alu(f3);
            dec_illegal = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        dec_illegal  = 1'b0;
        dec_use_imm  = 1'b1;
        dec_imm      = {in_instr[31:12], 12'b0};
        dec_rs1_zero = 1'b1;
      end
      default: ;
    endcase
    if (!idx_ok(rd) || (use_rs1 && !idx_ok(rs1)) || (use_rs2 && !idx_ok(rs2)))
      dec_illegal = 1'b1;
  end

  logic        valid_q, valid_d, wb_we_q, wb_we_d, use_imm_q, use_imm_d, illegal_q, illegal_d;
  logic [31:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  alu_q, alu_d;

  // Fields hold on flush and bubbles; an illegal bundle carries zeros besides its flags.
  always_comb begin
    valid_d    = 1'b0;
    illegal_d  = illegal_q;
    wb_we_d    = wb_we_q;
    use_imm_d  = use_imm_q;
    rd_d       = rd_q;
    alu_d      = alu_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    if (!flush && accept) begin
      valid_d    = 1'b1;
      illegal_d  = dec_illegal;
      wb_we_d    = !dec_illegal;
      use_imm_d  = !dec_illegal && dec_use_imm;
      rd_d       = dec_illegal ? 5'd0 : rd;
      alu_d      = dec_illegal ? ALU_ADD : dec_alu;
      rs1_data_d = (dec_illegal || dec_rs1_zero) ? 32'd0 : rs1_rd;
      rs2_data_d = dec_illegal ? 32'd0 : rs2_rd;
      imm_d      = dec_illegal ? 32'd0 : dec_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      wb_we_q    <= 1'b0;
      use_imm_q  <= 1'b0;
      rd_q       <= '0;
      alu_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      wb_we_q    <= wb_we_d;
      use_imm_q  <= use_imm_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  assign id_ex_valid      = valid_q;
  assign id_ex_illegal    = illegal_q;
  assign id_ex_wb_we      = wb_we_q;
  assign id_ex_use_imm    = use_imm_q;
  assign id_ex_rd         = rd_q;
  assign id_ex_alu_opcode = alu_q;
  assign id_ex_rs1_data   = rs1_data_q;
  assign id_ex_rs2_data   = rs2_data_q;
  assign id_ex_imm_i      = imm_q;

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Decode/register-read stage. Takes a 32-bit RV32I instruction from fetch and decodes OP, OP-IMM and LUI.
- Holds the architectural register file and presents a registered ID/EX bundle to the EX/WB stage.
- Consumes the EX/WB write-back port (wb_we/wb_rd/wb_data) to update the register file. Closes the loop between fetch and execute.

Parameters:
- NREG, 32: number of architectural registers (32, or 16 for RV32E). A source or destination index >= NREG makes the instruction illegal.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch presents in_instr
- in_ready  output  1  stage accepts in_instr this cycle
- in_instr  input  32  instruction word
- flush  input  1  kill ID/EX contents this cycle
- wb_we  input  1  write-back enable from EX/WB
- wb_rd  input  5  write-back destination
- wb_data  input  32  write-back value
- id_ex_valid  output  1  bundle valid
- id_ex_rs1_data  output  32  operand A
- id_ex_rs2_data  output  32  operand B (register)
- id_ex_imm_i  output  32  immediate: sign-extended I-imm, or U-imm for LUI
- id_ex_rd  output  5  destination
- id_ex_wb_we  output  1  instruction writes rd
- id_ex_alu_opcode  output  4  ALU op
- id_ex_use_imm  output  1  ALU B = immediate
- id_ex_illegal  output  1  bundle carries an undecodable instruction

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset state:
  - All id_ex_* outputs are 0.
  - All NREG registers are cleared to 0.
  - in_ready is 1 in the cycle after reset deasserts.
- Register file:
  - Write at the posedge when wb_we=1 and wb_rd!=0 and wb_rd<NREG.
  - x0 always reads 0.
  - Two combinational read ports, indexed by in_instr[19:15] and in_instr[24:20].
- Decode (latched on accept):
  - OP (0110011): use_imm=0.
  - OP-IMM (0010011): use_imm=1, imm = sign-extended instr[31:20].
  - LUI (0110111): rs1_data forced to 0, imm = {instr[31:12],12'b0}, use_imm=1, alu_opcode=ADD.
- ALU opcode encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - SUB is OP with funct7=0100000.
  - SRA requires funct7=0100000 for both OP and OP-IMM.
- Illegal instructions:
  - Any other opcode, funct7/funct3 combination, or register index >= NREG is illegal.
  - Illegal bundle: id_ex_valid=1, id_ex_illegal=1, id_ex_wb_we=0. Other fields are don't-care but must be deterministic (zero).
- wb_we semantics: id_ex_wb_we=1 for every legal decoded instruction. rd=0 is allowed; the write is suppressed in the regfile.
- Pipeline register update, every posedge:
  - if reset: clear;
  - elif flush: id_ex_valid<=0 (other fields hold);
  - elif in_valid && in_ready: load the decoded bundle, id_ex_valid<=1;
  - else: id_ex_valid<=0 (bubble), fields hold.
- Accept/flush interaction: an instruction accepted in the same cycle as flush is discarded. in_ready is not lowered by flush.
- Latency: 1 cycle from accept to id_ex_valid.
- RAW hazard handling: a source register (rs1/rs2, nonzero) equal to wb_rd while wb_we=1 is a hazard. Handling is set by the optional feature below.

Optional Feature:
- Macro: ID_BYPASS_EN.
- Defined:
  - Write-first bypass: a hazardous read returns wb_data in the same cycle.
  - in_ready is constantly 1 (except during reset).
- Undefined:
  - Hazard deasserts in_ready combinationally for that cycle. No accept occurs and a bubble is inserted.
  - The next cycle reads the updated register.
  - Back-to-back dependent instructions therefore incur exactly 1 stall cycle.
- Functional results are identical in both builds; only the timing differs.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) valid one cycle -> next cycle id_ex_valid=1, rd=1, imm_i=5, use_imm=1, alu_opcode=0, rs1_data=0, wb_we=1.
- Drive wb_we=1, wb_rd=1, wb_data=5 while presenting ADD x2,x1,x1 (0x00108133):
  - bypass build: same-cycle accept, rs1_data=rs2_data=5;
  - non-bypass build: in_ready=0 for 1 cycle, then accept with rs1_data=rs2_data=5.
- SRAI x3,x1,2 with funct7=0100000 -> alu_opcode=7, imm_i[4:0]=2. Same encoding with funct7=0000001 -> id_ex_illegal=1, id_ex_wb_we=0, id_ex_valid=1.
- LUI x4,0x12345 (0x12345237) -> imm_i=0x12345000, rs1_data=0, use_imm=1, alu_opcode=0.
- Write x0 via wb_we=1, wb_rd=0, wb_data=0xFFFFFFFF, then ADD x5,x0,x0 -> rs1_data=rs2_data=0.
- Flush and accept in the same cycle -> id_ex_valid=0 next cycle. Reset asserted mid-stream with a valid bundle -> all outputs 0 next cycle and subsequent reads of x1 return 0.
